// File: rtl/cmp_guess_ctrl.sv
// Number-guessing game controller wrapped around an external 4-bit magnitude
// comparator: registers secret/guess onto the comparator and scores its result.
module cmp_guess_ctrl #(
  parameter int unsigned MAX_TRIES = 7
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       set_i,
  input  logic       try_i,
  input  logic [3:0] d_i,
  output logic [3:0] cmp_a_o,
  output logic [3:0] cmp_b_o,
  input  logic [2:0] cmp_q_i,
  output logic       busy_o,
  output logic       high_o,
  output logic       low_o,
  output logic       win_o,
  output logic       lose_o,
  output logic [3:0] tries_o
);

  localparam int unsigned DW = 4;
  localparam int unsigned QW = 3;

  localparam logic [QW-1:0] CMP_GT    = 3'b100;
  localparam logic [QW-1:0] CMP_EQ    = 3'b010;
  localparam logic [QW-1:0] CMP_LT    = 3'b001;
  localparam logic [DW-1:0] TRIES_MAX = DW'(MAX_TRIES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READY,
    ST_EVAL,
    ST_WIN,
    ST_LOSE
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] cmp_a_q, cmp_a_d;
  logic [DW-1:0] cmp_b_q, cmp_b_d;
  logic [DW-1:0] tries_q, tries_d;
  logic          busy_q, busy_d;
  logic          high_q, high_d;
  logic          low_q, low_d;
  logic          win_q, win_d;
  logic          lose_q, lose_d;
  logic [DW-1:0] tries_inc_c;
  logic          restart_c;

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cmp_a_q <= '0;
      cmp_b_q <= '0;
      tries_q <= '0;
      busy_q  <= 1'b0;
      high_q  <= 1'b0;
      low_q   <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmp_a_q <= cmp_a_d;
      cmp_b_q <= cmp_b_d;
      tries_q <= tries_d;
      busy_q  <= busy_d;
      high_q  <= high_d;
      low_q   <= low_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

  // Next-state and output logic; SET is honoured everywhere except EVAL
  always_comb begin
    state_d     = state_q;
    cmp_a_d     = cmp_a_q;
    cmp_b_d     = cmp_b_q;
    tries_d     = tries_q;
    busy_d      = 1'b0;
    high_d      = high_q;
    low_d       = low_q;
    win_d       = win_q;
    lose_d      = lose_q;
    tries_inc_c = tries_q + DW'(1);
    restart_c   = set_i && (state_q != ST_EVAL);

    if (restart_c) begin
      cmp_b_d = d_i;
      tries_d = '0;
      high_d  = 1'b0;
      low_d   = 1'b0;
      win_d   = 1'b0;
      lose_d  = 1'b0;
      state_d = ST_READY;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_READY: begin
          if (try_i) begin
            cmp_a_d = d_i;
            busy_d  = 1'b1;
            state_d = ST_EVAL;
          end
        end
        ST_EVAL: begin
          high_d  = 1'b0;
          low_d   = 1'b0;
          state_d = ST_READY;
          case (cmp_q_i)
            CMP_EQ: begin
              tries_d = tries_inc_c;
              win_d   = 1'b1;
              state_d = ST_WIN;
            end
            CMP_GT, CMP_LT: begin
              tries_d = tries_inc_c;
              high_d  = (cmp_q_i == CMP_GT);
              low_d   = (cmp_q_i == CMP_LT);
              if (tries_inc_c == TRIES_MAX) begin
                lose_d  = 1'b1;
                state_d = ST_LOSE;
              end
            end
            // Glitched/illegal comparator code: the guess is not charged
            default: begin
              tries_d = tries_q;
            end
          endcase
        end
        ST_WIN, ST_LOSE: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign cmp_a_o = cmp_a_q;
  assign cmp_b_o = cmp_b_q;
  assign tries_o = tries_q;
  assign busy_o  = busy_q;
  assign high_o  = high_q;
  assign low_o   = low_q;
  assign win_o   = win_q;
  assign lose_o  = lose_q;

endmodule

// File: doc/cmp_guess_ctrl.md
Name: cmp_guess_ctrl

Overview:
- Sequential controller for a number-guessing game built around the team's 4-bit magnitude comparator.
- The block sits on both sides of the comparator:
  - upstream, it registers the secret and the guess and drives them onto the comparator A/B inputs;
  - downstream, it consumes the comparator's 3-bit result, updates HIGH/LOW hints and an attempt counter, and declares WIN or LOSE.

Parameters:
- MAX_TRIES, default 7: guesses allowed per game. Legal range 1..15.

Ports:
- CLK    in   1  single system clock, rising edge.
- RST    in   1  asynchronous, active-high reset.
- SET    in   1  single-cycle pulse: load D as the secret and start a new game.
- TRY    in   1  single-cycle pulse: submit D as a guess.
- D      in   4  secret/guess data, unsigned.
- CMP_A  out  4  registered guess; drives comparator A.
- CMP_B  out  4  registered secret; drives comparator B.
- CMP_Q  in   3  comparator result: [2]=A>B, [1]=A==B, [0]=A<B. Legal codes are 100, 010 and 001.
- BUSY   out  1  high while a guess is being evaluated.
- HIGH   out  1  last evaluated guess was above the secret.
- LOW    out  1  last evaluated guess was below the secret.
- WIN    out  1  game won; held until the next SET.
- LOSE   out  1  game lost; held until the next SET.
- TRIES  out  4  number of guesses consumed this game.

Behaviour:
- Clocking and reset:
  - One clock, CLK. Reset RST is asynchronous and active-high.
  - While RST=1: state=IDLE; CMP_A=CMP_B=0; TRIES=0; BUSY=HIGH=LOW=WIN=LOSE=0.
  - Reset asserted mid-evaluation aborts the evaluation immediately; no flag updates.
- All outputs are registered.
- States: IDLE, READY, EVAL, WIN, LOSE.
- IDLE:
  - SET: CMP_B<=D, TRIES<=0, HIGH=LOW=0, go to READY.
  - TRY is ignored.
- READY:
  - SET (priority over a simultaneous TRY) restarts the game: CMP_B<=D, TRIES<=0, HIGH=LOW=0.
  - TRY alone: CMP_A<=D, BUSY<=1, go to EVAL.
- EVAL: exactly one cycle, giving the comparator a full settle cycle. At the closing edge, BUSY<=0, CMP_Q is sampled, and:
  - CMP_Q=010: TRIES+1, HIGH=LOW=0, go to WIN. WIN has priority even when this is the MAX_TRIES-th guess.
  - CMP_Q=100: TRIES+1, HIGH=1, LOW=0.
  - CMP_Q=001: TRIES+1, LOW=1, HIGH=0.
  - After a 100 or 001 result: if the new TRIES==MAX_TRIES go to LOSE, else go to READY.
  - Any illegal CMP_Q code (000, 011, 101, 110, 111): TRIES unchanged, HIGH=LOW=0, go to READY. The guess is not charged.
  - SET and TRY are ignored during EVAL (one-cycle window; the user must re-pulse).
- WIN/LOSE:
  - WIN or LOSE stays high; TRIES, CMP_A and CMP_B hold.
  - TRY is ignored.
  - SET: clear WIN/LOSE/HIGH/LOW, TRIES<=0, CMP_B<=D, go to READY.
- Latency: TRY sampled at edge k → CMP_A valid after edge k; flags and TRIES valid after edge k+1. Throughput is one guess per 2 cycles minimum.
- Width rules:
  - TRIES is 4-bit unsigned and cannot exceed MAX_TRIES (the LOSE state blocks further increments), so it never wraps.
  - D=0 and D=15 are valid secrets and guesses.
- Output invariants: WIN and LOSE are never both high; HIGH and LOW are never both high.
- SET and TRY are level-sampled at each edge. Holding TRY high in READY starts a new evaluation every 2 cycles, which is legal.

Test Plan:
- The bench closes the loop through the team's 4-bit comparator; MAX_TRIES=7.
- Reset then SET D=9 → CMP_B=9, TRIES=0, state READY; all flags 0.
- TRY D=3, then TRY D=12 → after the first result LOW=1, HIGH=0, TRIES=1; after the second HIGH=1, LOW=0, TRIES=2. In both cases flags update exactly 2 edges after TRY, and BUSY is high for 1 cycle.
- TRY D=9 → WIN=1, HIGH=LOW=0, TRIES=3. Further TRY D=0 → no change. SET D=0 → WIN=0, TRIES=0, CMP_B=0.
- Secret 15, seven guesses of 0 → TRIES=7, LOSE=1, LOW=1. An 8th TRY is ignored. Separately, a correct 7th guess gives WIN=1, LOSE=0.
- Force CMP_Q=000 and 111 (comparator bypassed) during EVAL → TRIES unchanged, HIGH=LOW=0, back to READY.
- SET and TRY together in READY (SET D=4) → CMP_B=4, TRIES=0, no EVAL. Async RST pulsed mid-EVAL → all outputs 0 without waiting for a clock edge.
